// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LS chunk first,
// with the inter-chunk carry held in a register. Valid/ready on both sides.
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic             in_ready_reg, out_valid_reg;
  logic             cout_reg, ovf_reg;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_ch;
  logic             msb_cin;

  // Operands are shifted down as they are consumed, so the active chunk is
  // always the bottom CHUNK bits and no wide index mux is needed.
  assign a_ch = a_reg[CHUNK-1:0];
  assign b_ch = b_reg[CHUNK-1:0];
  assign {c_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_reg};

  // Carry into the result MSB, recovered from the MSB's own sum bit.
  assign msb_cin    = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
  assign last_chunk = (k_reg == KW'(NCHUNK - 1));
  assign accept     = in_valid & in_ready_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept)     state_next = S_CALC;
      S_CALC:  if (last_chunk) state_next = S_DONE;
      S_DONE:  if (out_ready)  state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      k_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == S_IDLE);
      out_valid_reg <= (state_next == S_DONE);
      if (accept) begin
        a_reg     <= in1;
        b_reg     <= sub ? ~in2 : in2;
        carry_reg <= sub | cin;
        k_reg     <= '0;
      end else if (state_reg == S_CALC) begin
        a_reg     <= a_reg >> CHUNK;
        b_reg     <= b_reg >> CHUNK;
        carry_reg <= c_ch;
        if (!last_chunk) begin
          k_reg <= k_reg + KW'(1);
        end else begin
          cout_reg <= c_ch;
          ovf_reg  <= msb_cin ^ c_ch;
        end
      end
    end
  end

  // One register per result chunk; each is written only on its own cycle so
  // untouched chunks keep their previous value.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_part
    logic [CHUNK-1:0] part_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        part_reg <= '0;
      end else if ((state_reg == S_CALC) && (k_reg == KW'(gi))) begin
        part_reg <= s_ch;
      end
    end

    assign sum[gi*CHUNK +: CHUNK] = part_reg;
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule
